// File: rtl/ram_copy_engine_if.sv
// Command and RAM-port bundle for ram_copy_engine.
// The engine takes the master view: it receives commands and drives the RAM pins.
// The slave view is for the controller and RAM side.
interface ram_copy_engine_if #(
    parameter int A = 10,
    parameter int D = 8
);
    logic         start;
    logic         mode;
    logic [A-1:0] src;
    logic [A-1:0] dst;
    logic [A:0]   len;
    logic [D-1:0] pattern;
    logic         busy;
    logic         done;
    logic         ram_cs;
    logic         ram_rw;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_di;
    logic [D-1:0] ram_dout;

    modport master (
        input  start, mode, src, dst, len, pattern, ram_dout,
        output busy, done, ram_cs, ram_rw, ram_addr, ram_di
    );

    modport slave (
        output start, mode, src, dst, len, pattern, ram_dout,
        input  busy, done, ram_cs, ram_rw, ram_addr, ram_di
    );
endinterface

// File: rtl/ram_copy_engine.sv
// Block copy / fill engine driving a single-port synchronous RAM.
// Copy alternates read and write cycles in ascending order; fill issues back-to-back writes.
// Every RAM-facing output is decoded from registered state except the copy-mode write data,
// which forwards the RAM's registered read data straight through.
module ram_copy_engine #(
    parameter int A = 10,
    parameter int D = 8
) (
    input logic               clk,
    input logic               rst,
    ram_copy_engine_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [A:0] ONE = 1;

    state_t       state_q, state_d;
    logic [A:0]   i_q, i_d;
    logic [A:0]   len_q, len_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [D-1:0] pattern_q, pattern_d;
    logic         mode_q, mode_d;
    logic [A:0]   i_inc;

    assign i_inc = i_q + ONE;

    // State and latched command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            pattern_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            len_q     <= len_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
        end
    end

    // Next state: accept a command in IDLE, then step the word index after every write.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        len_d     = len_q;
        src_d     = src_q;
        dst_d     = dst_q;
        pattern_d = pattern_q;
        mode_d    = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d     = bus.src;
                    dst_d     = bus.dst;
                    len_d     = bus.len;
                    pattern_d = bus.pattern;
                    mode_d    = bus.mode;
                    i_d       = '0;
                    if (bus.len == '0) begin
                        state_d = DONE;
                    end else if (bus.mode) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = WR;
            WR: begin
                i_d = i_inc;
                if (i_inc == len_q) begin
                    state_d = DONE;
                end else if (mode_q) begin
                    state_d = WR;
                end else begin
                    state_d = RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM pins and status decoded from state; addresses wrap modulo 2^A.
    always_comb begin
        bus.ram_cs   = 1'b0;
        bus.ram_rw   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_di   = '0;
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == DONE);
        unique case (state_q)
            RD: begin
                bus.ram_cs   = 1'b1;
                bus.ram_addr = src_q + i_q[A-1:0];
            end
            WR: begin
                bus.ram_cs   = 1'b1;
                bus.ram_rw   = 1'b1;
                bus.ram_addr = dst_q + i_q[A-1:0];
                bus.ram_di   = mode_q ? pattern_q : bus.ram_dout;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_copy_engine.sv
// Testbench for ram_copy_engine: behavioural RAM, array-level copy/fill model,
// directed table, hand-written corner sequences and a randomized command phase.
`timescale 1ns/1ps
module tb_ram_copy_engine;
    localparam int A   = 10;
    localparam int D   = 8;
    localparam int N   = 1 << A;
    localparam int AW1 = A + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_copy_engine_if #(.A(A), .D(D)) bus ();
    ram_copy_engine #(.A(A), .D(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    ram_copy_engine_if #(.A(4), .D(D)) bus4 ();
    ram_copy_engine #(.A(4), .D(D)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [D-1:0] mem      [N];
    logic [D-1:0] init_mem [N];
    logic [D-1:0] ref_mem  [N];
    logic         load_req;
    int           exp_wa   [N];
    int           exp_wd   [N];
    logic [D-1:0] mem4     [16];
    int           wcnt4    [16];

    int checks = 0;
    int errors = 0;

    // Behavioural RAM for the main engine, with a bulk-load port for preloading.
    always @(posedge clk) begin
        if (load_req === 1'b1) begin
            for (int j = 0; j < N; j++) mem[j] = init_mem[j];
        end else if (bus.ram_cs === 1'b1) begin
            if (bus.ram_rw) mem[bus.ram_addr] = bus.ram_di;
            else bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    // Behavioural RAM for the 16-word engine, counting writes per address.
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 16; j++) wcnt4[j] = 0;
        end else if (bus4.ram_cs === 1'b1) begin
            if (bus4.ram_rw) begin
                mem4[bus4.ram_addr] = bus4.ram_di;
                wcnt4[bus4.ram_addr]++;
            end else begin
                bus4.ram_dout <= mem4[bus4.ram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_ram();
        for (int j = 0; j < N; j++) init_mem[j] = ref_mem[j];
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int j = 0; j < N; j++) if (mem[j] !== ref_mem[j]) n++;
        return n;
    endfunction

    function automatic int exp_done_cycle(input logic m, input int l);
        if (l == 0) return 1;
        return m ? l + 1 : 2 * l + 1;
    endfunction

    // Reference: words move one at a time in ascending order, so overlap falls out naturally.
    task automatic model_cmd(input logic m, input int s, input int d, input int l, input int p);
        int v;
        for (int w = 0; w < l; w++) begin
            v = m ? p : int'(ref_mem[(s + w) % N]);
            exp_wa[w] = (d + w) % N;
            exp_wd[w] = v;
            ref_mem[(d + w) % N] = D'(v);
        end
    endtask

    task automatic run_cmd(input string tag, input logic m, input int s, input int d,
                           input int l, input int p, input int inj_k, output int nwr);
        int k, w, done_at, ndone, nbusy, nseq, exp_done;
        logic ecs, erw;
        logic [A-1:0] ea;
        logic [D-1:0] ed;
        k = 0; done_at = 0; ndone = 0; nbusy = 0; nseq = 0; nwr = 0;
        exp_done = exp_done_cycle(m, l);
        model_cmd(m, s, d, l, p);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.src = A'(s); bus.dst = A'(d);
        bus.len = AW1'(l); bus.pattern = D'(p);
        while (done_at == 0 && k < exp_done + 8) begin
            @(negedge clk);
            k++;
            bus.start = (k == inj_k);
            if (k == inj_k) begin
                bus.mode = ~m; bus.src = A'(d); bus.dst = A'(s);
                bus.len = AW1'(2); bus.pattern = '1;
            end
            ecs = 1'b0; erw = 1'b0; ea = '0; ed = '0;
            if (!m && k <= 2 * l) begin
                w   = (k - 1) / 2;
                ecs = 1'b1;
                erw = (k % 2 == 0);
                ea  = erw ? A'(exp_wa[w]) : A'((s + w) % N);
                ed  = erw ? D'(exp_wd[w]) : '0;
            end else if (m && k <= l) begin
                ecs = 1'b1; erw = 1'b1;
                ea  = A'(exp_wa[k - 1]);
                ed  = D'(exp_wd[k - 1]);
            end
            if (bus.ram_cs !== ecs || bus.ram_rw !== erw ||
                (ecs && bus.ram_addr !== ea) || ((erw || !ecs) && bus.ram_di !== ed)) nseq++;
            if (bus.busy === 1'b1) nbusy++;
            if (bus.ram_cs === 1'b1 && bus.ram_rw === 1'b1) nwr++;
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_at == 0) done_at = k;
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, " idle_after"}, {bus.busy, bus.done, bus.ram_cs}, 3'b000);
        check({tag, " done_cycle"}, done_at, exp_done);
        check({tag, " done_width"}, ndone, 1);
        check({tag, " busy_cycles"}, nbusy, exp_done);
        check({tag, " access_seq_errs"}, nseq, 0);
        check({tag, " mem_diff"}, mem_diff(), 0);
    endtask

    typedef struct {
        logic m;
        int   s;
        int   d;
        int   l;
        int   p;
        int   exp_done;
        int   exp_nwr;
    } vec_t;
    vec_t vt [8];

    task automatic overlap_case(input int s, input int d, input int e0, input int e1,
                                input int e2, input int e3);
        int nwr;
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int j = 0; j < 4; j++) ref_mem[j] = D'(j + 1);
        load_ram();
        run_cmd($sformatf("ovl_s%0d_d%0d", s, d), 1'b0, s, d, 3, 0, 0, nwr);
        for (int j = 0; j < 4; j++) check($sformatf("ovl_s%0d_d%0d word%0d", s, d, j), mem[j], e[j]);
    endtask

    task automatic reset_case();
        int nseq, quiet;
        logic [D-1:0] kept;
        logic erw;
        nseq = 0; quiet = 0;
        kept = ref_mem['h242];
        model_cmd(1'b0, 'h20, 'h240, 2, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.src = A'('h20); bus.dst = A'('h240);
        bus.len = AW1'(6); bus.pattern = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            erw = (k % 2 == 0);
            if (bus.ram_cs !== 1'b1 || bus.ram_rw !== erw ||
                bus.ram_addr !== A'((erw ? 'h240 : 'h20) + (k - 1) / 2)) nseq++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_cs", bus.ram_cs, 0);
        check("rst_abort_busy", bus.busy, 0);
        check("rst_abort_done", bus.done, 0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ram_cs !== 1'b0) quiet++;
        end
        check("rst_pre_seq_errs", nseq, 0);
        check("rst_quiet_after", quiet, 0);
        check("rst_word2_unwritten", mem['h242], kept);
        check("rst_mem_diff", mem_diff(), 0);
    endtask

    task automatic full_len_a4();
        int k, done_at, ndone, total, bad, badv;
        k = 0; done_at = 0; ndone = 0; total = 0; bad = 0; badv = 0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.mode = 1'b1; bus4.dst = 4'h7; bus4.len = 5'd16; bus4.pattern = 8'h5A;
        while (k < 30) begin
            @(negedge clk);
            k++;
            bus4.start = 1'b0;
            if (bus4.done === 1'b1) begin
                ndone++;
                if (done_at == 0) done_at = k;
            end
        end
        for (int j = 0; j < 16; j++) begin
            total += wcnt4[j];
            if (wcnt4[j] != 1) bad++;
            if (mem4[j] !== 8'h5A) badv++;
        end
        check("a4_full done_cycle", done_at, 17);
        check("a4_full done_width", ndone, 1);
        check("a4_full total_writes", total, 16);
        check("a4_full addr_not_once", bad, 0);
        check("a4_full value_errs", badv, 0);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        logic [D-1:0] saved2;
        logic m;
        int s, d, l, p;

        rst = 1'b1; load_req = 1'b0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.pattern = '0;
        bus4.start = 1'b0; bus4.mode = 1'b0; bus4.src = '0; bus4.dst = '0; bus4.len = '0;
        bus4.pattern = '0;
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset ram_cs", bus.ram_cs, 0);
        check("reset ram_rw", bus.ram_rw, 0);
        check("reset ram_addr", bus.ram_addr, 0);
        check("reset ram_di", bus.ram_di, 0);
        rst = 1'b0;

        for (int j = 0; j < N; j++) ref_mem[j] = D'($urandom);
        for (int j = 0; j < 4; j++) ref_mem['h10 + j] = D'('h11 * (j + 1));
        load_ram();
        saved2 = ref_mem[2];

        vt[0] = '{1'b0, 'h10,  'h80,  4,    'h00, 9,    4};
        vt[1] = '{1'b1, 0,     'h3FE, 4,    'hA5, 5,    4};
        vt[2] = '{1'b0, 5,     9,     0,    'h00, 1,    0};
        vt[3] = '{1'b1, 0,     'h30,  0,    'h66, 1,    0};
        vt[4] = '{1'b0, 'h3FF, 'h200, 1,    'h00, 3,    1};
        vt[5] = '{1'b1, 0,     'h123, 1,    'h3C, 2,    1};
        vt[6] = '{1'b0, 'h3FD, 'h3FE, 5,    'h00, 11,   5};
        vt[7] = '{1'b1, 0,     'h155, 1024, 'h77, 1025, 1024};
        for (int v = 0; v < 8; v++) begin
            run_cmd($sformatf("vec%0d", v), vt[v].m, vt[v].s, vt[v].d, vt[v].l, vt[v].p, 0, nwr);
            check($sformatf("vec%0d writes", v), nwr, vt[v].exp_nwr);
            check($sformatf("vec%0d done_vs_table", v), exp_done_cycle(vt[v].m, vt[v].l), vt[v].exp_done);
            if (v == 0) begin
                for (int j = 0; j < 4; j++)
                    check($sformatf("copy_dst word%0d", j), mem['h80 + j], 'h11 * (j + 1));
            end
            if (v == 1) check("fill_wrap ram2_unchanged", mem[2], saved2);
        end

        overlap_case(0, 1, 1, 1, 1, 1);
        overlap_case(1, 0, 2, 3, 4, 4);

        for (int j = 0; j < N; j++) ref_mem[j] = D'($urandom);
        load_ram();
        run_cmd("busy_start", 1'b0, 'h40, 'h300, 8, 0, 3, nwr);
        check("busy_start writes", nwr, 8);

        reset_case();
        full_len_a4();

        for (int t = 0; t < 30; t++) begin
            m = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            s = int'($urandom_range(0, N - 1));
            d = ($urandom_range(0, 2) == 0) ? (s + int'($urandom_range(0, 6))) % N
                                             : int'($urandom_range(0, N - 1));
            p = int'($urandom_range(0, 255));
            run_cmd($sformatf("rnd%0d", t), m, s, d, l, p, 0, nwr);
            check($sformatf("rnd%0d writes", t), nwr, l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
